// File: rtl/vu_cmd_ximm_queues.sv
// vu_cmd_ximm_queues
//   Paired command / scalar-immediate queues that sit behind the vector block
//   decoder. A decoded instruction goes into cmdq, ximm1q, or both, in one
//   step. If any queue it needs is full, nothing is written and replay is
//   raised so the decoder can present the instruction again. The vector unit
//   drains each queue on its own through a valid/ready port.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   io_valid                 decoded instruction present
//   io_sigs_enq_cmdq/ximm1q  queues this instruction needs
//   io_cmd_bits/io_imm_bits  payloads
//   io_replay, io_fire       reject / accept for this cycle (combinational)
//   io_cmdq_ready/ximm1q_ready  queue not full (from registered counts)
//   io_deq_cmd_*, io_deq_ximm1_*  head of each queue, valid/ready
//   io_cmdq_count, io_ximm1q_count  occupancy

// Circular-buffer queue. Ready comes from the registered count only, so a pop
// in the same cycle does not free a slot for a push. An empty queue does not
// pass data straight through to the output.
module vu_cmd_ximm_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq,
    input  logic [W-1:0]             enq_bits,
    output logic                     ready,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [W-1:0]             deq_bits,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_deq;

    assign ready     = count < (AW+1)'(DEPTH);
    assign deq_valid = count != '0;
    assign deq_bits  = mem[rd_ptr];
    assign do_deq    = deq_valid & deq_ready;

    // Storage is not reset. The caller gates enq with fire, and fire is low
    // while reset is high.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= enq_bits;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)    wr_ptr <= wr_ptr + AW'(1);
            if (do_deq) rd_ptr <= rd_ptr + AW'(1);
            case ({enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module vu_cmd_ximm_queues #(
    parameter int CMD_W        = 20,
    parameter int IMM_W        = 64,
    parameter int CMDQ_DEPTH   = 4,
    parameter int XIMM1Q_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            io_valid,
    input  logic                            io_sigs_enq_cmdq,
    input  logic                            io_sigs_enq_ximm1q,
    input  logic [CMD_W-1:0]                io_cmd_bits,
    input  logic [IMM_W-1:0]                io_imm_bits,
    output logic                            io_replay,
    output logic                            io_fire,
    output logic                            io_cmdq_ready,
    output logic                            io_ximm1q_ready,
    output logic                            io_deq_cmd_valid,
    input  logic                            io_deq_cmd_ready,
    output logic [CMD_W-1:0]                io_deq_cmd_bits,
    output logic                            io_deq_ximm1_valid,
    input  logic                            io_deq_ximm1_ready,
    output logic [IMM_W-1:0]                io_deq_ximm1_bits,
    output logic [$clog2(CMDQ_DEPTH):0]     io_cmdq_count,
    output logic [$clog2(XIMM1Q_DEPTH):0]   io_ximm1q_count
);
    logic blocked;

    // Decide accept or reject for both queues together, so that an instruction
    // is written to all the queues it needs or to none of them.
    // While reset is high, every valid instruction is replayed.
    assign blocked   = (io_sigs_enq_cmdq   & ~io_cmdq_ready) |
                       (io_sigs_enq_ximm1q & ~io_ximm1q_ready);
    assign io_replay = io_valid & (reset | blocked);
    assign io_fire   = io_valid & ~io_replay;

    vu_cmd_ximm_fifo #(.W(CMD_W), .DEPTH(CMDQ_DEPTH)) u_cmdq (
        .clk       (clk),
        .reset     (reset),
        .enq       (io_fire & io_sigs_enq_cmdq),
        .enq_bits  (io_cmd_bits),
        .ready     (io_cmdq_ready),
        .deq_valid (io_deq_cmd_valid),
        .deq_ready (io_deq_cmd_ready),
        .deq_bits  (io_deq_cmd_bits),
        .count     (io_cmdq_count)
    );

    vu_cmd_ximm_fifo #(.W(IMM_W), .DEPTH(XIMM1Q_DEPTH)) u_ximm1q (
        .clk       (clk),
        .reset     (reset),
        .enq       (io_fire & io_sigs_enq_ximm1q),
        .enq_bits  (io_imm_bits),
        .ready     (io_ximm1q_ready),
        .deq_valid (io_deq_ximm1_valid),
        .deq_ready (io_deq_ximm1_ready),
        .deq_bits  (io_deq_ximm1_bits),
        .count     (io_ximm1q_count)
    );
endmodule

// File: tb/tb_vu_cmd_ximm_queues.sv
module tb_vu_cmd_ximm_queues;
    logic        clk = 1'b0;
    logic        reset;
    logic        io_valid, io_sigs_enq_cmdq, io_sigs_enq_ximm1q;
    logic [19:0] io_cmd_bits;
    logic [63:0] io_imm_bits;
    logic        io_replay, io_fire, io_cmdq_ready, io_ximm1q_ready;
    logic        io_deq_cmd_valid, io_deq_cmd_ready;
    logic [19:0] io_deq_cmd_bits;
    logic        io_deq_ximm1_valid, io_deq_ximm1_ready;
    logic [63:0] io_deq_ximm1_bits;
    logic [2:0]  io_cmdq_count, io_ximm1q_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vu_cmd_ximm_queues dut (
        .clk(clk), .reset(reset),
        .io_valid(io_valid), .io_sigs_enq_cmdq(io_sigs_enq_cmdq),
        .io_sigs_enq_ximm1q(io_sigs_enq_ximm1q),
        .io_cmd_bits(io_cmd_bits), .io_imm_bits(io_imm_bits),
        .io_replay(io_replay), .io_fire(io_fire),
        .io_cmdq_ready(io_cmdq_ready), .io_ximm1q_ready(io_ximm1q_ready),
        .io_deq_cmd_valid(io_deq_cmd_valid), .io_deq_cmd_ready(io_deq_cmd_ready),
        .io_deq_cmd_bits(io_deq_cmd_bits),
        .io_deq_ximm1_valid(io_deq_ximm1_valid), .io_deq_ximm1_ready(io_deq_ximm1_ready),
        .io_deq_ximm1_bits(io_deq_ximm1_bits),
        .io_cmdq_count(io_cmdq_count), .io_ximm1q_count(io_ximm1q_count)
    );

    // advance one clock, then settle 1ns past the edge before driving/sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io_valid = 0; io_sigs_enq_cmdq = 0; io_sigs_enq_ximm1q = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle(); io_deq_cmd_ready = 0; io_deq_ximm1_ready = 0;
        io_cmd_bits = '0; io_imm_bits = '0;
        tick(); tick();
        io_valid = 1; io_sigs_enq_cmdq = 1; #1;
        n_checks++; if (io_replay !== 1'b1) begin n_fail++; $display("FAIL reset_replay: got %0b exp 1", io_replay); end
        n_checks++; if (io_fire !== 1'b0) begin n_fail++; $display("FAIL reset_fire: got %0b exp 0", io_fire); end
        tick();
        reset = 0; idle(); #1;
        n_checks++; if ({io_cmdq_count, io_ximm1q_count} !== 6'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", io_cmdq_count, io_ximm1q_count); end
        n_checks++; if ({io_deq_cmd_valid, io_deq_ximm1_valid, io_cmdq_ready, io_ximm1q_ready} !== 4'b0011) begin n_fail++; $display("FAIL reset_flags: got %b exp 0011", {io_deq_cmd_valid, io_deq_ximm1_valid, io_cmdq_ready, io_ximm1q_ready}); end
    endtask

    task automatic test_single();
        io_valid = 1; io_sigs_enq_cmdq = 1; io_cmd_bits = 20'h0ABCD; #1;
        n_checks++; if (io_fire !== 1'b1) begin n_fail++; $display("FAIL single_fire: got %0b exp 1", io_fire); end
        n_checks++; if (io_deq_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %0b exp 0", io_deq_cmd_valid); end
        tick(); idle(); #1;
        n_checks++; if (io_deq_cmd_valid !== 1'b1 || io_deq_cmd_bits !== 20'h0ABCD) begin n_fail++; $display("FAIL single_head: got v=%0b %h exp v=1 0abcd", io_deq_cmd_valid, io_deq_cmd_bits); end
        n_checks++; if (io_cmdq_count !== 3'd1 || io_ximm1q_count !== 3'd0 || io_deq_ximm1_valid !== 1'b0) begin n_fail++; $display("FAIL single_counts: got %0d/%0d xv=%0b exp 1/0 xv=0", io_cmdq_count, io_ximm1q_count, io_deq_ximm1_valid); end
        io_deq_cmd_ready = 1; tick(); io_deq_cmd_ready = 0; #1;
        n_checks++; if (io_cmdq_count !== 3'd0 || io_deq_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got cnt=%0d v=%0b exp 0 0", io_cmdq_count, io_deq_cmd_valid); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            io_valid = 1; io_sigs_enq_cmdq = 1; io_cmd_bits = 20'h100 + 20'(i);
            tick();
        end
        idle(); #1;
        n_checks++; if (io_cmdq_count !== 3'd4 || io_cmdq_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got cnt=%0d rdy=%0b exp 4 0", io_cmdq_count, io_cmdq_ready); end
        io_valid = 1; io_sigs_enq_cmdq = 1; io_sigs_enq_ximm1q = 1;
        io_cmd_bits = 20'h00999; io_imm_bits = 64'hDEAD; #1;
        n_checks++; if (io_replay !== 1'b1 || io_fire !== 1'b0) begin n_fail++; $display("FAIL full_replay: got r=%0b f=%0b exp 1 0", io_replay, io_fire); end
        tick(); idle(); #1;
        n_checks++; if (io_ximm1q_count !== 3'd0 || io_cmdq_count !== 3'd4) begin n_fail++; $display("FAIL full_atomic: got %0d/%0d exp 4/0", io_cmdq_count, io_ximm1q_count); end
    endtask

    task automatic test_full_deq();
        logic [19:0] exp_q [4];
        exp_q[0] = 20'h101; exp_q[1] = 20'h102; exp_q[2] = 20'h103; exp_q[3] = 20'h200;
        io_deq_cmd_ready = 1; io_valid = 1; io_sigs_enq_cmdq = 1; io_cmd_bits = 20'h200; #1;
        n_checks++; if (io_replay !== 1'b1) begin n_fail++; $display("FAIL fulldeq_replay: got %0b exp 1", io_replay); end
        tick();
        io_deq_cmd_ready = 0; #1;
        n_checks++; if (io_cmdq_ready !== 1'b1 || io_fire !== 1'b1) begin n_fail++; $display("FAIL fulldeq_refire: got rdy=%0b f=%0b exp 1 1", io_cmdq_ready, io_fire); end
        tick(); idle(); #1;
        n_checks++; if (io_cmdq_count !== 3'd4) begin n_fail++; $display("FAIL fulldeq_count: got %0d exp 4", io_cmdq_count); end
        io_deq_cmd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (io_deq_cmd_valid !== 1'b1 || io_deq_cmd_bits !== exp_q[i]) begin n_fail++; $display("FAIL fulldeq_order%0d: got %h exp %h", i, io_deq_cmd_bits, exp_q[i]); end
            tick();
        end
        io_deq_cmd_ready = 0; #1;
        n_checks++; if (io_cmdq_count !== 3'd0) begin n_fail++; $display("FAIL fulldeq_empty: got %0d exp 0", io_cmdq_count); end
    endtask

    task automatic test_back_to_back();
        io_deq_cmd_ready = 1; io_deq_ximm1_ready = 1;
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) begin
                io_valid = 1; io_sigs_enq_cmdq = 1; io_sigs_enq_ximm1q = 1;
                io_cmd_bits = 20'(k); io_imm_bits = 64'hF000_0000_0000_0000 | 64'(k);
            end else idle();
            #1;
            n_checks++; if (io_fire !== (k < 10)) begin n_fail++; $display("FAIL stream_fire%0d: got %0b exp %0b", k, io_fire, k < 10); end
            if (k >= 1) begin
                n_checks++; if (io_deq_cmd_valid !== 1'b1 || io_deq_cmd_bits !== 20'(k-1)) begin n_fail++; $display("FAIL stream_cmd%0d: got v=%0b %h exp %h", k, io_deq_cmd_valid, io_deq_cmd_bits, k-1); end
                n_checks++; if (io_deq_ximm1_valid !== 1'b1 || io_deq_ximm1_bits !== (64'hF000_0000_0000_0000 | 64'(k-1))) begin n_fail++; $display("FAIL stream_imm%0d: got %h", k, io_deq_ximm1_bits); end
                n_checks++; if (io_cmdq_count !== 3'd1 || io_ximm1q_count !== 3'd1) begin n_fail++; $display("FAIL stream_count%0d: got %0d/%0d exp 1/1", k, io_cmdq_count, io_ximm1q_count); end
            end
            tick();
        end
        io_deq_cmd_ready = 0; io_deq_ximm1_ready = 0; #1;
        n_checks++; if (io_cmdq_count !== 3'd0 || io_ximm1q_count !== 3'd0) begin n_fail++; $display("FAIL stream_end: got %0d/%0d exp 0/0", io_cmdq_count, io_ximm1q_count); end
    endtask

    task automatic test_no_flags();
        io_valid = 1; io_sigs_enq_ximm1q = 1; io_imm_bits = 64'h1234; tick();
        idle(); io_valid = 1; #1;
        n_checks++; if (io_fire !== 1'b1 || io_replay !== 1'b0) begin n_fail++; $display("FAIL noflag_fire: got f=%0b r=%0b exp 1 0", io_fire, io_replay); end
        tick(); idle(); #1;
        n_checks++; if (io_cmdq_count !== 3'd0 || io_ximm1q_count !== 3'd1) begin n_fail++; $display("FAIL noflag_counts: got %0d/%0d exp 0/1", io_cmdq_count, io_ximm1q_count); end
    endtask

    task automatic test_ximm_full();
        for (int i = 0; i < 3; i++) begin
            io_valid = 1; io_sigs_enq_ximm1q = 1; io_imm_bits = 64'(i); tick();
        end
        idle(); #1;
        n_checks++; if (io_ximm1q_ready !== 1'b0 || io_ximm1q_count !== 3'd4) begin n_fail++; $display("FAIL xfull_state: got rdy=%0b cnt=%0d exp 0 4", io_ximm1q_ready, io_ximm1q_count); end
        io_valid = 1; io_sigs_enq_cmdq = 1; io_cmd_bits = 20'h777; #1;
        n_checks++; if (io_fire !== 1'b1) begin n_fail++; $display("FAIL xfull_cmd_only: got %0b exp 1", io_fire); end
        tick();
        io_sigs_enq_ximm1q = 1; io_cmd_bits = 20'h778; #1;
        n_checks++; if (io_replay !== 1'b1) begin n_fail++; $display("FAIL xfull_both: got %0b exp 1", io_replay); end
        tick(); idle(); #1;
        n_checks++; if (io_cmdq_count !== 3'd1 || io_deq_cmd_bits !== 20'h777) begin n_fail++; $display("FAIL xfull_atomic: got cnt=%0d %h exp 1 777", io_cmdq_count, io_deq_cmd_bits); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            io_valid = 1; io_sigs_enq_cmdq = 1; io_cmd_bits = 20'h300 + 20'(i); tick();
        end
        idle(); #1;
        n_checks++; if (io_cmdq_count !== 3'd3) begin n_fail++; $display("FAIL mid_pre: got %0d exp 3", io_cmdq_count); end
        reset = 1; io_valid = 1; io_sigs_enq_cmdq = 1; io_deq_cmd_ready = 1; #1;
        n_checks++; if (io_fire !== 1'b0 || io_replay !== 1'b1) begin n_fail++; $display("FAIL mid_reset: got f=%0b r=%0b exp 0 1", io_fire, io_replay); end
        tick();
        reset = 0; idle(); io_deq_cmd_ready = 0; #1;
        n_checks++; if (io_cmdq_count !== 3'd0 || io_ximm1q_count !== 3'd0) begin n_fail++; $display("FAIL mid_counts: got %0d/%0d exp 0/0", io_cmdq_count, io_ximm1q_count); end
        n_checks++; if ({io_deq_cmd_valid, io_deq_ximm1_valid, io_cmdq_ready, io_ximm1q_ready} !== 4'b0011) begin n_fail++; $display("FAIL mid_flags: got %b exp 0011", {io_deq_cmd_valid, io_deq_ximm1_valid, io_cmdq_ready, io_ximm1q_ready}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_full_deq();
        test_back_to_back();
        test_no_flags();
        test_ximm_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
